interp2_mac_sched: RTL

INTERP2_MAC_SCHED -- requirements
Module: interp2_mac_sched

---
 rtl/interp2_mac_sched.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/interp2_mac_sched.sv
// ---------------------------------------------------------------------------
// interp2_mac_sched: 2x interpolator tap scheduler for one shared MAC, with
// shadow/active coefficient banks. Optional macro: INTERP2_OVERRUN_CNT_EN.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module interp2_mac_sched (
  input  logic        sys_clk,
  input  logic        reset,
  input  logic        sam_clk_en,
  input  logic        coef_wr_en,
  input  logic [1:0]  coef_wr_addr,
  input  logic [17:0] coef_wr_data,
  input  logic        coef_swap,
  input  logic        overrun_clr,
  output logic [1:0]  tap_sel,
  output logic [17:0] coef,
  output logic        phase,
  output logic        acc_clr,
  output logic        acc_en,
  output logic        y_valid,
  output logic        busy,
  output logic        swap_pending,
  output logic        overrun,
  output logic [7:0]  overrun_cnt
);

  localparam logic [17:0] RST_COEF0 = -18'sd4744;
  localparam logic [17:0] RST_COEF1 = 18'sd0;
  localparam logic [17:0] RST_COEF2 = 18'sd37451;
  localparam logic [17:0] RST_COEF3 = 18'sd65536;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_P0A  = 3'd1,
    S_P0B  = 3'd2,
    S_P0V  = 3'd3,
    S_P1A  = 3'd4,
    S_P1B  = 3'd5,
    S_P1V  = 3'd6
  } state_t;

  state_t      state_q, state_d;
  logic [17:0] shadow_q [4];
  logic [17:0] shadow_d [4];
  logic [17:0] active_q [4];
  logic [17:0] active_d [4];
  logic        swap_pending_q, swap_pending_d;
  logic        overrun_q, overrun_d;
  logic        sample_ignored;
  logic        swap_window;

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      shadow_q       <= '{RST_COEF0, RST_COEF1, RST_COEF2, RST_COEF3};
      active_q       <= '{RST_COEF0, RST_COEF1, RST_COEF2, RST_COEF3};
      swap_pending_q <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      shadow_q       <= shadow_d;
      active_q       <= active_d;
      swap_pending_q <= swap_pending_d;
      overrun_q      <= overrun_d;
    end
  end

  // Sequencer: even phase uses taps 0/2, odd phase taps 1/3.
  always_comb begin
    state_d = state_q;
    tap_sel = 2'd0;
    phase   = 1'b0;
    acc_clr = 1'b0;
    acc_en  = 1'b0;
    y_valid = 1'b0;
    busy    = (state_q != S_IDLE);
    case (state_q)
      S_IDLE: if (sam_clk_en) state_d = S_P0A;
      S_P0A: begin
        state_d = S_P0B;
        acc_clr = 1'b1;
        acc_en  = 1'b1;
      end
      S_P0B: begin
        state_d = S_P0V;
        tap_sel = 2'd2;
        acc_en  = 1'b1;
      end
      S_P0V: begin
        state_d = S_P1A;
        y_valid = 1'b1;
      end
      S_P1A: begin
        state_d = S_P1B;
        tap_sel = 2'd1;
        acc_clr = 1'b1;
        acc_en  = 1'b1;
      end
      S_P1B: begin
        state_d = S_P1V;
        tap_sel = 2'd3;
        acc_en  = 1'b1;
      end
      S_P1V: begin
        y_valid = 1'b1;
        phase   = 1'b1;
        state_d = sam_clk_en ? S_P0A : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign sample_ignored = sam_clk_en && (state_q != S_IDLE) && (state_q != S_P1V);
  assign swap_window    = (state_q == S_IDLE) || (state_q == S_P1V);

  always_comb begin
    overrun_d = overrun_q;
    if (sample_ignored)   overrun_d = 1'b1;
    else if (overrun_clr) overrun_d = 1'b0;
  end

  // The copy takes the post-write shadow so a same-cycle write is included.
  always_comb begin
    shadow_d       = shadow_q;
    active_d       = active_q;
    swap_pending_d = swap_pending_q;
    if (coef_wr_en) shadow_d[coef_wr_addr] = coef_wr_data;
    if ((swap_pending_q || coef_swap) && swap_window) begin
      active_d       = shadow_d;
      swap_pending_d = 1'b0;
    end else if (coef_swap) begin
      swap_pending_d = 1'b1;
    end
  end

  assign coef         = active_q[tap_sel];
  assign swap_pending = swap_pending_q;
  assign overrun      = overrun_q;

`ifdef INTERP2_OVERRUN_CNT_EN
  logic [7:0] overrun_cnt_q, overrun_cnt_d;

  always_comb begin
    overrun_cnt_d = overrun_cnt_q;
    if (sample_ignored) begin
      if (overrun_cnt_q != 8'hFF) overrun_cnt_d = overrun_cnt_q + 8'd1;
    end else if (overrun_clr) begin
      overrun_cnt_d = 8'd0;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (reset) overrun_cnt_q <= 8'd0;
    else       overrun_cnt_q <= overrun_cnt_d;
  end

  assign overrun_cnt = overrun_cnt_q;
`else
  assign overrun_cnt = 8'd0;
`endif

endmodule

`default_nettype wire
